// File: rtl/clksel_pkg.sv
// Shared types and constants for the HS/LS CPU clock-switch sequencer.
package clksel_pkg;

  typedef enum logic [1:0] {
    ST_SLOW    = 2'd0,
    ST_TO_FAST = 2'd1,
    ST_FAST    = 2'd2,
    ST_TO_SLOW = 2'd3
  } clksel_state_e;

  // Bit positions inside cfg_wdata
  localparam int unsigned CFG_TURBO_BIT = 0;
  localparam int unsigned CFG_DIV_BIT   = 1;
  localparam int unsigned CFG_DELAY_BIT = 2;
  localparam int unsigned CFG_W         = 3;

  function automatic logic is_transit(input clksel_state_e st);
    return (st == ST_TO_FAST) || (st == ST_TO_SLOW);
  endfunction

endpackage

// File: rtl/clksel_sequencer_sync_ff.sv
// Multi-flop synchroniser for one asynchronous feedback bit from the clock switch.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  assign sync_d = {sync_q[STAGES-2:0], d_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/clksel_sequencer.sv
// Sequences hsclk_sel for the HS/LS CPU clock switch, waits for its feedback,
// and applies divider/delay configuration only while running on the LS clock.
//
// state      | meaning
// SLOW       | LS clock selected and acknowledged; config may be applied
// TO_FAST    | hsclk_sel raised, waiting for hs ack / ls release
// FAST       | HS clock selected and acknowledged
// TO_SLOW    | hsclk_sel dropped, waiting for ls ack / hs release
module clksel_sequencer
  import clksel_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_DWELL   = 8,
  parameter int unsigned TIMEOUT     = 64,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             hsclk_in,
  input  logic             rst,
  input  logic             fast_req,
  input  logic             slow_req,
  input  logic             cfg_we,
  input  logic [CFG_W-1:0] cfg_wdata,
  input  logic             hsclk_selected_in,
  input  logic             lsclk_selected_in,
  output logic             hsclk_sel,
  output logic             cpuclk_div_sel,
  output logic             delay_sel,
  output logic             fast_active,
  output logic             busy,
  output logic             timeout_err
);

  localparam logic [CNT_W-1:0] DWELL_C    = CNT_W'(MIN_DWELL);
  localparam logic [CNT_W-1:0] TMO_LAST_C = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX_C  = '1;

  clksel_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hsclk_sel_q, hsclk_sel_d;
  logic             tmo_err_q, tmo_err_d;
  logic             turbo_q, turbo_d;
  logic             div_q, div_d;
  logic             dly_q, dly_d;
  logic             div_sh_q, div_sh_d;
  logic             dly_sh_q, dly_sh_d;
  logic             pend_q, pend_d;

  logic             hs_ack;
  logic             ls_ack;
  logic             dwell_done;
  logic             cnt_clr;
  logic             tmo_set;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_hs (
    .clk_i (hsclk_in),
    .rst_i (rst),
    .d_i   (hsclk_selected_in),
    .q_o   (hs_ack)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_ls (
    .clk_i (hsclk_in),
    .rst_i (rst),
    .d_i   (lsclk_selected_in),
    .q_o   (ls_ack)
  );

  assign dwell_done = (cnt_q >= DWELL_C);

  always_ff @(posedge hsclk_in or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SLOW;
      hsclk_sel_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hsclk_sel_q <= hsclk_sel_d;
    end
  end

  // Requests are deliberately ignored in the transit states: a switch is never aborted.
  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    tmo_set = 1'b0;
    case (state_q)
      ST_SLOW: begin
        if (turbo_q && fast_req && !slow_req && dwell_done && !tmo_err_q && !pend_q) begin
          state_d = ST_TO_FAST;
          cnt_clr = 1'b1;
        end
      end
      ST_TO_FAST: begin
        if (hs_ack && !ls_ack) begin
          state_d = ST_FAST;
          cnt_clr = 1'b1;
        end else if (cnt_q == TMO_LAST_C) begin
          state_d = ST_TO_SLOW;
          cnt_clr = 1'b1;
          tmo_set = 1'b1;
        end
      end
      ST_FAST: begin
        if (slow_req || ((!fast_req || !turbo_q) && dwell_done)) begin
          state_d = ST_TO_SLOW;
          cnt_clr = 1'b1;
        end
      end
      ST_TO_SLOW: begin
        if (ls_ack && !hs_ack) begin
          state_d = ST_SLOW;
          cnt_clr = 1'b1;
        end else if (cnt_q == TMO_LAST_C) begin
          tmo_set = 1'b1;
        end
      end
      default: begin
        state_d = ST_SLOW;
        cnt_clr = 1'b1;
      end
    endcase
  end

  always_comb begin
    hsclk_sel_d = (state_d == ST_TO_FAST) || (state_d == ST_FAST);
    fast_active = (state_q == ST_FAST);
    busy        = is_transit(state_q) || pend_q;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX_C) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // A timeout raised on the same edge as a config write stays set.
  always_comb begin
    tmo_err_d = tmo_err_q;
    if (tmo_set) begin
      tmo_err_d = 1'b1;
    end else if (cfg_we) begin
      tmo_err_d = 1'b0;
    end
  end

  always_comb begin
    turbo_d  = turbo_q;
    div_d    = div_q;
    dly_d    = dly_q;
    div_sh_d = div_sh_q;
    dly_sh_d = dly_sh_q;
    pend_d   = pend_q;
    if (cfg_we) begin
      turbo_d = cfg_wdata[CFG_TURBO_BIT];
    end
    if ((state_q == ST_SLOW) && (pend_q || cfg_we)) begin
      div_d  = cfg_we ? cfg_wdata[CFG_DIV_BIT]   : div_sh_q;
      dly_d  = cfg_we ? cfg_wdata[CFG_DELAY_BIT] : dly_sh_q;
      pend_d = 1'b0;
    end else if (cfg_we) begin
      div_sh_d = cfg_wdata[CFG_DIV_BIT];
      dly_sh_d = cfg_wdata[CFG_DELAY_BIT];
      pend_d   = 1'b1;
    end
  end

  always_ff @(posedge hsclk_in or posedge rst) begin
    if (rst) begin
      cnt_q     <= DWELL_C;
      tmo_err_q <= 1'b0;
      turbo_q   <= 1'b0;
      div_q     <= 1'b0;
      dly_q     <= 1'b0;
      div_sh_q  <= 1'b0;
      dly_sh_q  <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      tmo_err_q <= tmo_err_d;
      turbo_q   <= turbo_d;
      div_q     <= div_d;
      dly_q     <= dly_d;
      div_sh_q  <= div_sh_d;
      dly_sh_q  <= dly_sh_d;
      pend_q    <= pend_d;
    end
  end

  assign hsclk_sel      = hsclk_sel_q;
  assign cpuclk_div_sel = div_q;
  assign delay_sel      = dly_q;
  assign timeout_err    = tmo_err_q;

endmodule
